cmplxmult_pipe: RTL and testbench
=================================

CMPLXMULT_PIPE -- requirements
Module: cmplxmult_pipe

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning operand/result width per real or imaginary component, signed two's complement.
REQ-002 SHALL have parameter FRAC_BITS, default 15, meaning fractional bits of the fixed-point format, legal range 1..BIT_WIDTH-1.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have ports real_a, img_a, real_b, img_b  input  BIT_WIDTH each  operands a and b.
REQ-006 SHALL have port conj_b  input  1  1 = multiply a by conj(b); sampled with operands.
REQ-007 SHALL have port round_en  input  1  1 = round-half-up, 0 = truncate toward -inf; sampled with operands.
REQ-008 SHALL have port in_valid  input  1  operands valid this cycle.
REQ-009 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-010 SHALL have ports real_prod, img_prod  output  BIT_WIDTH each  registered complex product.
REQ-011 SHALL have port out_valid  output  1  product valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts product.
REQ-013 SHALL have port ovf  output  1  this output word saturated (either component), qualified by out_valid.
REQ-014 SHALL have port ovf_sticky  output  1  any saturation since reset or clear.
REQ-015 SHALL have port ovf_clear  input  1  clears ovf_sticky.

Function
REQ-016 SHALL be a 3-stage pipeline: S1 registers operands and mode bits; S2 registers four full-width 2*BIT_WIDTH signed products ra*rb, ia*ib, ra*ib, ia*rb; S3 registers sums, rounding, saturation.
REQ-017 SHALL hold one valid bit per stage; advance = !out_valid | out_ready; all stages load only when advance = 1, otherwise hold.
REQ-018 SHALL drive in_ready = advance; a transfer occurs when in_valid & in_ready; S1 valid loads in_valid on advance.
REQ-019 SHALL give latency exactly 3 clk from accepted input to out_valid with no stall; throughput one result per cycle.
REQ-020 SHALL compute, at 2*BIT_WIDTH+1 bits: conj_b=0: re = ra*rb - ia*ib, im = ra*ib + ia*rb; conj_b=1: re = ra*rb + ia*ib, im = ia*rb - ra*ib (no operand negation, so -2^(BIT_WIDTH-1) in img_b is exact).
REQ-021 SHALL, when round_en=1, add 2^(FRAC_BITS-1) before arithmetic right shift by FRAC_BITS; when 0, shift only.
REQ-022 SHALL saturate each shifted component to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1]; ovf = 1 if either component clipped.
REQ-023 SHALL set ovf_sticky on any output-stage load with valid data and ovf = 1; ovf_clear deasserts it next cycle; simultaneous set and clear -> set wins.
REQ-024 SHALL keep real_prod, img_prod, ovf stable while out_valid & !out_ready.
REQ-025 SHALL not modify data registers of stages whose valid bit is 0 beyond normal loading (bubbles propagate; contents don't-care).

Reset
REQ-026 SHALL on reset clear all stage valid bits, out_valid, ovf, ovf_sticky, and zero real_prod, img_prod, next cycle; in_ready = 1 the cycle after reset deasserts.
REQ-027 SHALL discard in-flight data when reset asserts mid-operation; no out_valid until 3 cycles after a post-reset accept.
REQ-028 SHALL ignore in_valid during reset.

Verification
REQ-029 SHALL verify: Q1.15, round_en=0, a=(0x4000,0x4000), b=(0x4000,0x4000), conj_b=0 -> 3 cycles later real_prod=0x0000, img_prod=0x4000, ovf=0.
REQ-030 SHALL verify: a=(0x4000,0x4000), b=(0x4000,0x4000), conj_b=1 -> real_prod=0x4000, img_prod=0x0000.
REQ-031 SHALL verify: a=(0x8000,0x8000), b=(0x8000,0x0000) -> real_prod=0x7FFF, img_prod=0x7FFF, ovf=1, ovf_sticky=1 until ovf_clear pulse.
REQ-032 SHALL verify: a=(0x0001,0), b=(0x4000,0): round_en=1 -> real_prod=0x0001; round_en=0 -> 0x0000; a=(0xFFFF,0) round_en=0 -> 0xFFFF.
REQ-033 SHALL verify: back-to-back 5 inputs with out_ready=0 from cycle 2 -> in_ready drops once pipeline full, outputs held stable, all 5 results delivered in order after out_ready=1, none lost or duplicated.
REQ-034 SHALL verify: reset asserted with 3 results in flight -> out_valid=0, outputs zero, none of those results appear after reset.

Source files
------------

// File: rtl/cmplxmult_pipe.sv
// cmplxmult_pipe: 3-stage pipelined fixed-point complex multiplier with optional conjugate, rounding and saturation
//   clk, reset               rising-edge clock, synchronous active-high reset
//   real_a/img_a/real_b/img_b operands (signed, FRAC_BITS fractional bits), conj_b/round_en mode bits
//   in_valid/in_ready         input handshake
//   real_prod/img_prod/ovf    registered product and per-word saturation flag
//   out_valid/out_ready       output handshake
//   ovf_sticky/ovf_clear      accumulated saturation flag and its clear
module cmplxmult_pipe #(
   parameter int BIT_WIDTH = 16,
   parameter int FRAC_BITS = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [BIT_WIDTH-1:0] real_a,
   input  logic [BIT_WIDTH-1:0] img_a,
   input  logic [BIT_WIDTH-1:0] real_b,
   input  logic [BIT_WIDTH-1:0] img_b,
   input  logic                 conj_b,
   input  logic                 round_en,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BIT_WIDTH-1:0] real_prod,
   output logic [BIT_WIDTH-1:0] img_prod,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 ovf,
   output logic                 ovf_sticky,
   input  logic                 ovf_clear
);
   localparam int W  = BIT_WIDTH;
   localparam int PW = 2 * W;
   localparam int SW = 2 * W + 2;
   localparam logic signed [SW-1:0] HALF = SW'(1) << (FRAC_BITS - 1);
   localparam logic signed [SW-1:0] MAXV = (SW'(1) << (W - 1)) - SW'(1);
   localparam logic signed [SW-1:0] MINV = ~MAXV;
   logic                   advance, v1, v2, conj1, rnd1, conj2, rnd2;
   logic signed [W-1:0]    ra, ia, rb, ib;
   logic signed [PW-1:0]   p_rr, p_ii, p_ri, p_ir;
   logic signed [SW-1:0]   bias, re_sum, im_sum, re_sh, im_sh;
   logic                   re_hi, re_lo, im_hi, im_lo, clip;
   logic [W-1:0]           re_sat, im_sat;
   // the whole pipeline freezes while the output word is waiting on the consumer
   assign advance  = !out_valid | out_ready;
   assign in_ready = advance;
   // conjugate form subtracts ra*ib instead of negating img_b, so the most negative img_b stays exact
   always_comb begin
      bias   = rnd2 ? HALF : '0;
      re_sum = (conj2 ? SW'(p_rr) + SW'(p_ii) : SW'(p_rr) - SW'(p_ii)) + bias;
      im_sum = (conj2 ? SW'(p_ir) - SW'(p_ri) : SW'(p_ri) + SW'(p_ir)) + bias;
      re_sh  = re_sum >>> FRAC_BITS;
      im_sh  = im_sum >>> FRAC_BITS;
      re_hi  = re_sh > MAXV;
      re_lo  = re_sh < MINV;
      im_hi  = im_sh > MAXV;
      im_lo  = im_sh < MINV;
      clip   = re_hi | re_lo | im_hi | im_lo;
      re_sat = re_hi ? MAXV[W-1:0] : re_lo ? MINV[W-1:0] : re_sh[W-1:0];
      im_sat = im_hi ? MAXV[W-1:0] : im_lo ? MINV[W-1:0] : im_sh[W-1:0];
   end
   // operand and product registers carry no reset; their valid bits qualify them
   always_ff @(posedge clk) begin
      if (advance) begin
         ra    <= real_a;
         ia    <= img_a;
         rb    <= real_b;
         ib    <= img_b;
         conj1 <= conj_b;
         rnd1  <= round_en;
         p_rr  <= PW'(ra) * PW'(rb);
         p_ii  <= PW'(ia) * PW'(ib);
         p_ri  <= PW'(ra) * PW'(ib);
         p_ir  <= PW'(ia) * PW'(rb);
         conj2 <= conj1;
         rnd2  <= rnd1;
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         v1        <= 1'b0;
         v2        <= 1'b0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
         real_prod <= '0;
         img_prod  <= '0;
      end else if (advance) begin
         v1        <= in_valid;
         v2        <= v1;
         out_valid <= v2;
         ovf       <= v2 & clip;
         if (v2) begin
            real_prod <= re_sat;
            img_prod  <= im_sat;
         end
      end
   end
   // a saturating load in the same cycle as ovf_clear keeps the flag set
   always_ff @(posedge clk) begin
      if (reset) ovf_sticky <= 1'b0;
      else if (advance & v2 & clip) ovf_sticky <= 1'b1;
      else if (ovf_clear) ovf_sticky <= 1'b0;
   end
endmodule

// File: tb/tb_cmplxmult_pipe.sv
// tb_cmplxmult_pipe: directed self-checking bench for cmplxmult_pipe (Q1.15)
module tb_cmplxmult_pipe;
   logic        clk = 1'b0, reset, conj_b, round_en, in_valid, in_ready;
   logic        out_valid, out_ready, ovf, ovf_sticky, ovf_clear;
   logic [15:0] real_a, img_a, real_b, img_b, real_prod, img_prod;
   logic [32:0] q[$];
   int          n_pass = 0, n_chk = 0;

   cmplxmult_pipe #(.BIT_WIDTH(16), .FRAC_BITS(15)) dut (
      .clk(clk), .reset(reset), .real_a(real_a), .img_a(img_a), .real_b(real_b), .img_b(img_b),
      .conj_b(conj_b), .round_en(round_en), .in_valid(in_valid), .in_ready(in_ready),
      .real_prod(real_prod), .img_prod(img_prod), .out_valid(out_valid), .out_ready(out_ready),
      .ovf(ovf), .ovf_sticky(ovf_sticky), .ovf_clear(ovf_clear)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (!reset && out_valid && out_ready) q.push_back({ovf, real_prod, img_prod});

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic drive(input logic [15:0] ar, ai, br, bi, input logic cj, rn);
      real_a = ar; img_a = ai; real_b = br; img_b = bi; conj_b = cj; round_en = rn;
   endtask

   task automatic send(input logic [15:0] ar, ai, br, bi, input logic cj, rn);
      logic acc = 1'b0;
      drive(ar, ai, br, bi, cj, rn);
      in_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      chk("accept", {31'd0, acc}, 1);
   endtask

   task automatic wait_n(input int n);
      for (int k = 0; k < 40 && q.size() < n; k++) @(negedge clk);
      chk("n_out", q.size(), n);
   endtask

   task automatic run(input string tag, input logic [15:0] ar, ai, br, bi, input logic cj, rn,
                      input logic [15:0] er, ei, input logic eo);
      logic [32:0] got;
      @(posedge clk);
      #1;
      q.delete();
      send(ar, ai, br, bi, cj, rn);
      wait_n(1);
      got = 'x;
      if (q.size() > 0) got = q[0];
      chk({tag, "_re"}, got[31:16], er);
      chk({tag, "_im"}, got[15:0], ei);
      chk({tag, "_ovf"}, got[32], eo);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; ovf_clear = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_ov", out_valid, 0);
      chk("rst_re", real_prod, 0);
      chk("rst_im", img_prod, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_sticky", ovf_sticky, 0);
      chk("rst_rdy", in_ready, 1);
      // latency: presented in cycle 0, visible in cycle 3
      @(posedge clk);
      #1 drive(16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 0);
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("lat_c1", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_c2", out_valid, 0);
      @(posedge clk);
      @(negedge clk);
      chk("lat_c3", out_valid, 1);
      chk("q29_re", real_prod, 16'h0000);
      chk("q29_im", img_prod, 16'h4000);
      chk("q29_ovf", ovf, 0);
      run("q30", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 1, 0, 16'h4000, 16'h0000, 0);
      run("q31", 16'h8000, 16'h8000, 16'h8000, 16'h0000, 0, 0, 16'h7FFF, 16'h7FFF, 1);
      chk("sticky_set", ovf_sticky, 1);
      run("rnd", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 0, 1, 16'h0001, 16'h0000, 0);
      chk("sticky_hold", ovf_sticky, 1);
      run("trunc", 16'h0001, 16'h0000, 16'h4000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0);
      run("negtr", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 0, 0, 16'hFFFF, 16'h0000, 0);
      run("negrnd", 16'hFFFF, 16'h0000, 16'h4000, 16'h0000, 0, 1, 16'h0000, 16'h0000, 0);
      run("ibmin_cj", 16'h0000, 16'h4000, 16'h0000, 16'h8000, 1, 0, 16'hC000, 16'h0000, 0);
      run("ibmin", 16'h0000, 16'h4000, 16'h0000, 16'h8000, 0, 0, 16'h4000, 16'h0000, 0);
      run("negsat", 16'h8000, 16'h7FFF, 16'h7FFF, 16'h7FFF, 0, 0, 16'h8000, 16'hFFFF, 1);
      @(posedge clk);
      #1 ovf_clear = 1'b1;
      @(posedge clk);
      #1 ovf_clear = 1'b0;
      @(negedge clk);
      chk("sticky_clr", ovf_sticky, 0);
      // clear held high while a saturating word loads: set wins, then clears
      @(posedge clk);
      #1 ovf_clear = 1'b1;
      send(16'h8000, 16'h8000, 16'h8000, 16'h0000, 0, 0);
      for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
      chk("sw_ov", out_valid, 1);
      chk("sw_sticky", ovf_sticky, 1);
      @(posedge clk);
      @(negedge clk);
      chk("sw_clr", ovf_sticky, 0);
      ovf_clear = 1'b0;
      // back-to-back with consumer stalled from cycle 2
      @(posedge clk);
      #1 q.delete();
      fork
         for (int k = 1; k <= 5; k++) send(16'h4000, 16'h0000, 16'(k * 256), 16'h0000, 0, 0);
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (2) @(posedge clk);
            @(negedge clk);
            chk("stall_rdy", in_ready, 0);
            chk("stall_ov", out_valid, 1);
            chk("stall_re", real_prod, 16'h0080);
            repeat (3) begin
               @(negedge clk);
               chk("stall_hold", real_prod, 16'h0080);
            end
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      wait_n(5);
      repeat (5) @(negedge clk);
      chk("stall_cnt", q.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < q.size()) begin
            chk("stall_re_i", q[i][31:16], 32'((i + 1) * 128));
            chk("stall_im_i", q[i][15:0], 0);
         end
      // reset with three results in flight, in_valid asserted during reset
      @(posedge clk);
      #1 out_ready = 1'b0;
      q.delete();
      for (int k = 1; k <= 3; k++) send(16'h4000, 16'h0000, 16'(k * 256), 16'h0000, 0, 0);
      @(negedge clk);
      chk("pre_rst_ov", out_valid, 1);
      reset = 1'b1;
      in_valid = 1'b1;
      drive(16'h4000, 16'h0000, 16'h7000, 16'h0000, 0, 0);
      @(posedge clk);
      @(negedge clk);
      chk("mid_rst_ov", out_valid, 0);
      chk("mid_rst_re", real_prod, 0);
      chk("mid_rst_im", img_prod, 0);
      @(posedge clk);
      #1 reset = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      q.delete();
      repeat (8) @(negedge clk);
      chk("flush", q.size(), 0);
      run("post", 16'h4000, 16'h4000, 16'h4000, 16'h4000, 0, 0, 16'h0000, 16'h4000, 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
